// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one outstanding memory command at a time, round-robin on ties.
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 win every tie instead.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state;
    logic   owner;
    logic   pick;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    always_comb begin
        pick = ~req0;
    end
`else
    logic last_gnt;

    // Tie goes to whichever port was not served last.
    always_comb begin
        pick = req1;
        if (req0 && req1)
            pick = ~last_gnt;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_gnt  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= pick;
                        mem_req   <= 1'b1;
                        mem_we    <= pick ? we1    : we0;
                        mem_addr  <= pick ? addr1  : addr0;
                        mem_wdata <= pick ? wdata1 : wdata0;
                        busy      <= 1'b1;
                        state     <= BUSY;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        last_gnt  <= pick;
`endif
                    end
                end
                BUSY: begin
                    // Command registers double as the latched request copy.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we)
                            rdata <= mem_rdata;
                        ack0    <= ~owner;
                        ack1    <= owner;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written corner sequences and
// randomized requesters checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Reference model: transaction phase 0=idle, 1=command out, 2=acknowledging.
    int            m_phase;
    bit            m_owner, m_last;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    // Memory responder knobs.
    int            wait_cnt, cur_delay;
    logic [DW-1:0] rd_val;
    bit            junk;

    function automatic bit winner(input bit r0, input bit r1, input bit last);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        return !r0;
`else
        if (r0 && r1) return !last;
        return r1;
`endif
    endfunction

    task automatic tick();
        bit            r0 = req0, r1 = req1, w0 = we0, w1 = we1, rdy = mem_ready;
        logic [AW-1:0] a0 = addr0, a1 = addr1;
        logic [DW-1:0] d0 = wdata0, d1 = wdata1, mrd = mem_rdata;
        @(posedge clk);
        #1;
        case (m_phase)
            0: if (r0 || r1) begin
                m_owner = winner(r0, r1, m_last);
                m_last  = m_owner;
                m_we    = m_owner ? w1 : w0;
                m_addr  = m_owner ? a1 : a0;
                m_wdata = m_owner ? d1 : d0;
                m_phase = 1;
            end
            1: if (rdy) begin
                if (!m_we) m_rdata = mrd;
                m_phase = 2;
            end
            default: m_phase = 0;
        endcase
        chkb("mem_req", mem_req, m_phase == 1);
        chkb("busy", busy, m_phase != 0);
        chkb("ack0", ack0, m_phase == 2 && !m_owner);
        chkb("ack1", ack1, m_phase == 2 && m_owner);
        chk("rdata", rdata, m_rdata);
        if (m_phase == 1) begin
            chkb("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (mem_req) begin
            mem_ready = (wait_cnt >= cur_delay);
            wait_cnt++;
        end else begin
            wait_cnt  = 0;
            mem_ready = junk ? 1'($urandom) : 1'b0;
            if (junk) cur_delay = $urandom_range(0, 3);
        end
        mem_rdata = mem_ready ? rd_val : $urandom;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chkb("rst_mem_req", mem_req, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_ack0", ack0, 1'b0);
        chkb("rst_ack1", ack1, 1'b0);
        chkb("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_rdata", rdata, '0);
        m_phase = 0; m_last = 1'b1; m_owner = 1'b0; m_rdata = '0;
        @(posedge clk);
        #1;
        chkb("rst_hold_ack0", ack0, 1'b0);
        chkb("rst_hold_req", mem_req, 1'b0);
        mem_ready = 1'b0;
        wait_cnt  = 0;
        reset_n   = 1'b1;
    endtask

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mrd;
        int            delay;
        int            lat;
        logic [DW-1:0] erd;
    } vec_t;

    int iss0 = 0, iss1 = 0, ak0 = 0, ak1 = 0;

    task automatic agents(input bit en);
        rd_val = $urandom;
        if (ack0) begin
            req0 = 1'b0; ak0++;
        end else if (!req0) begin
            we0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom;
            req0 = en && ($urandom_range(0, 3) == 0);
            if (req0) iss0++;
        end
        if (ack1) begin
            req1 = 1'b0; ak1++;
        end else if (!req1) begin
            we1 = 1'($urandom); addr1 = $urandom; wdata1 = $urandom;
            req1 = en && ($urandom_range(0, 3) == 0);
            if (req1) iss1++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t          tv[4];
        logic [AW-1:0] exp_rr[4];
        logic [AW-1:0] q[$];
        logic          p;
        int            lat, ack0_at, g1_at, n_ack1, n_g0;
        bit            got;

        tv[0] = '{port:1'b0, we:1'b1, addr:32'h10, wdata:32'hDEADBEEF, mrd:32'h0,
                  delay:0, lat:2, erd:32'h0};
        tv[1] = '{port:1'b1, we:1'b0, addr:32'h20, wdata:32'h0, mrd:32'h12345678,
                  delay:3, lat:5, erd:32'h12345678};
        tv[2] = '{port:1'b0, we:1'b0, addr:32'h44, wdata:32'h0, mrd:32'hA5A50F0F,
                  delay:1, lat:3, erd:32'hA5A50F0F};
        tv[3] = '{port:1'b1, we:1'b1, addr:32'h30, wdata:32'h0BADF00D, mrd:32'h11111111,
                  delay:2, lat:4, erd:32'hA5A50F0F};
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_rr = '{32'h100, 32'h100, 32'h100, 32'h100};
`else
        exp_rr = '{32'h100, 32'h200, 32'h100, 32'h200};
`endif

        reset_n = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        mem_ready = 0; mem_rdata = '0;
        junk = 0; cur_delay = 0; wait_cnt = 0; rd_val = '0;
        #2;
        do_reset();

        // Directed single-transaction vectors.
        for (int i = 0; i < 4; i++) begin
            rd_val = tv[i].mrd; cur_delay = tv[i].delay;
            if (tv[i].port) begin
                req1 = 1; we1 = tv[i].we; addr1 = tv[i].addr; wdata1 = tv[i].wdata;
            end else begin
                req0 = 1; we0 = tv[i].we; addr0 = tv[i].addr; wdata0 = tv[i].wdata;
            end
            got = 0; lat = 0;
            for (int c = 1; c <= 20 && !got; c++) begin
                tick();
                if (c == 1) begin
                    chkb("vec_cmd_req", mem_req, 1'b1);
                    chk("vec_cmd_addr", mem_addr, tv[i].addr);
                end
                if (ack0 || ack1) begin
                    got = 1; lat = c;
                    chkb("vec_ack_port", ack1, tv[i].port);
                    chk("vec_rdata", rdata, tv[i].erd);
                    req0 = 0; req1 = 0;
                end
            end
            chk("vec_latency", 32'(lat), 32'(tv[i].lat));
            tick();
        end

        // Both ports held high: grants alternate.
        do_reset();
        req0 = 1; we0 = 0; addr0 = 32'h100;
        req1 = 1; we1 = 0; addr1 = 32'h200;
        cur_delay = 0; p = mem_req;
        for (int c = 0; c < 40 && q.size() < 4; c++) begin
            tick();
            if (mem_req && !p) q.push_back(mem_addr);
            p = mem_req;
        end
        for (int k = 0; k < 4; k++)
            chk("rr_grant", (k < q.size()) ? q[k] : 32'hFFFFFFFF, exp_rr[k]);
        req0 = 0; req1 = 0;
        for (int c = 0; c < 6; c++) tick();

        // Port 1 arrives while port 0 is being served.
        req0 = 1; we0 = 1; addr0 = 32'h300; wdata0 = 32'h5555AAAA; cur_delay = 2;
        tick();
        chk("busy_grant0", mem_addr, 32'h300);
        tick();
        req1 = 1; we1 = 0; addr1 = 32'h400; rd_val = 32'h77778888;
        ack0_at = -1; g1_at = -1; n_ack1 = 0; n_g0 = 0; p = mem_req;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ack0) begin ack0_at = c; req0 = 0; end
            if (mem_req && !p) begin
                if (mem_addr == 32'h400) g1_at = c;
                else n_g0++;
            end
            if (ack1) begin n_ack1++; req1 = 0; end
            p = mem_req;
        end
        chkb("late_ack0_seen", ack0_at >= 0, 1'b1);
        chk("late_grant1_cycle", 32'(g1_at), 32'(ack0_at + 2));
        chk("late_ack1_count", 32'(n_ack1), 32'd1);
        chk("late_no_dup0", 32'(n_g0), 32'd0);

        // Reset in the middle of a long memory wait.
        req0 = 1; we0 = 0; addr0 = 32'h500; cur_delay = 10;
        tick();
        tick();
        chkb("pre_rst_busy", busy, 1'b1);
        do_reset();
        cur_delay = 0; rd_val = 32'hCAFE0001;
        tick();
        chkb("rst_regrant_req", mem_req, 1'b1);
        chk("rst_regrant_addr", mem_addr, 32'h500);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (ack0) begin got = 1; req0 = 0; end
        end
        chkb("rst_regrant_ack", got, 1'b1);
        tick();

        // Randomized traffic with spurious mem_ready outside transactions.
        junk = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            agents(1'b1);
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            agents(1'b0);
        end
        chk("rand_port0_acks", 32'(ak0), 32'(iss0));
        chk("rand_port1_acks", 32'(ak1), 32'(iss1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
